axis_i2s_transmitter: RTL and testbench

- Final output stage of the audio chain. Sits directly downstream of the AXIS volume controller.
- Accepts 32-bit AXIS audio words: signed 24-bit sample in bits [23:0]; s_axis_last=1 marks the right channel.
- Pairs left and right words and serializes them onto a Philips-format I2S link: 64 BCLK per frame, 24-bit sample in each 32-bit slot, MSB first, one-BCLK delay after each LRCK edge.
- Generates BCLK and LRCK itself, derived from the system clock.

---
 rtl/axis_i2s_transmitter.sv | 158 +++++++++++++++
 tb/tb_axis_i2s_transmitter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_i2s_transmitter.sv
// axis_i2s_transmitter
//   Final audio output stage. Pairs left/right AXIS words into a stereo holding
//   buffer and serialises each pair onto a Philips-format I2S link (64 BCLK per
//   frame, AUDIO_WIDTH-bit sample per 32-bit slot, MSB first, one BCLK after LRCK).
//   BCLK and LRCK are derived from clk.
// Ports:
//   clk, rst      : system clock, synchronous active-high reset
//   s_axis_data   : audio word, sample in [AUDIO_WIDTH-1:0]
//   s_axis_valid  : word valid
//   s_axis_ready  : buffer can take a word (registered)
//   s_axis_last   : 0 = left word, 1 = right word
//   i2s_bclk      : bit clock, falls when the divider wraps
//   i2s_lrck      : word select, 0 = left slot, 1 = right slot
//   i2s_sdata     : serial data, changes on BCLK falling edge
//   underrun      : 1-cycle pulse, frame loaded without a complete pair
//   sync_err      : 1-cycle pulse, left/right order violated on input
module axis_i2s_transmitter #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned AUDIO_WIDTH = 24,
  parameter int unsigned BCLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  input  logic                  s_axis_valid,
  output logic                  s_axis_ready,
  input  logic                  s_axis_last,
  output logic                  i2s_bclk,
  output logic                  i2s_lrck,
  output logic                  i2s_sdata,
  output logic                  underrun,
  output logic                  sync_err
);

  localparam int unsigned DIV_W = $clog2(BCLK_DIV);

  logic [DIV_W-1:0]         r_div_cnt;
  logic                     r_bclk;
  logic [5:0]               r_bit_cnt;
  logic                     r_lrck;
  logic                     r_sdata;
  logic [2*AUDIO_WIDTH-1:0] r_shift;
  logic [AUDIO_WIDTH-1:0]   r_hold_l;
  logic [AUDIO_WIDTH-1:0]   r_hold_r;
  logic                     r_pair_full;
  logic                     r_expect_right;
  logic                     r_ready;
  logic                     r_underrun;
  logic                     r_sync_err;

  logic                     w_fall_tick;
  logic [DIV_W-1:0]         w_div_next;
  logic [5:0]               w_bit_next;
  logic [4:0]               w_pos_next;
  logic                     w_data_bit;
  logic                     w_load;
  logic                     w_accept;
  logic [AUDIO_WIDTH-1:0]   w_sample;
  logic [AUDIO_WIDTH-1:0]   w_hold_l_next;
  logic [AUDIO_WIDTH-1:0]   w_hold_r_next;
  logic                     w_pair_full_next;
  logic                     w_expect_right_next;
  logic                     w_sync_err_next;

  if (DATA_WIDTH > AUDIO_WIDTH) begin : g_unused_bits
    logic w_unused_data;
    assign w_unused_data = ^s_axis_data[DATA_WIDTH-1:AUDIO_WIDTH];
  end

  assign w_fall_tick = (r_div_cnt == DIV_W'(BCLK_DIV - 1));
  assign w_div_next  = w_fall_tick ? '0 : r_div_cnt + DIV_W'(1);
  assign w_bit_next  = r_bit_cnt + 6'd1;
  assign w_pos_next  = w_bit_next[4:0];
  // Slot positions 1..AUDIO_WIDTH carry sample bits; position 0 and the tail pad with 0.
  assign w_data_bit  = (w_pos_next != 5'd0) && (w_pos_next <= 5'(AUDIO_WIDTH));
  assign w_load      = w_fall_tick && (r_bit_cnt == 6'd63);
  assign w_accept    = s_axis_valid && r_ready;
  assign w_sample    = s_axis_data[AUDIO_WIDTH-1:0];

  // Input pairing. Ready is low whenever the pair is full, so an accept and a
  // frame load that empties the buffer never target the same pair.
  always_comb begin
    w_hold_l_next       = r_hold_l;
    w_hold_r_next       = r_hold_r;
    w_pair_full_next    = r_pair_full;
    w_expect_right_next = r_expect_right;
    w_sync_err_next     = 1'b0;
    if (w_load && r_pair_full) begin
      w_pair_full_next = 1'b0;
    end
    if (w_accept) begin
      if (!s_axis_last) begin
        // A second left word replaces the first and still waits for a right.
        w_hold_l_next       = w_sample;
        w_expect_right_next = 1'b1;
        w_sync_err_next     = r_expect_right;
      end else if (r_expect_right) begin
        w_hold_r_next       = w_sample;
        w_pair_full_next    = 1'b1;
        w_expect_right_next = 1'b0;
      end else begin
        // Right word without a left: dropped.
        w_sync_err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt      <= '0;
      r_bclk         <= 1'b0;
      r_bit_cnt      <= '0;
      r_lrck         <= 1'b0;
      r_sdata        <= 1'b0;
      r_shift        <= '0;
      r_hold_l       <= '0;
      r_hold_r       <= '0;
      r_pair_full    <= 1'b0;
      r_expect_right <= 1'b0;
      r_ready        <= 1'b0;
      r_underrun     <= 1'b0;
      r_sync_err     <= 1'b0;
    end else begin
      r_div_cnt      <= w_div_next;
      // Registered from the next count so BCLK falls together with the serial outputs.
      r_bclk         <= (w_div_next >= DIV_W'(BCLK_DIV / 2));
      r_hold_l       <= w_hold_l_next;
      r_hold_r       <= w_hold_r_next;
      r_pair_full    <= w_pair_full_next;
      r_expect_right <= w_expect_right_next;
      r_ready        <= !w_pair_full_next;
      // Uses the registered flag: a pair completing on the load tick waits a frame.
      r_underrun     <= w_load && !r_pair_full;
      r_sync_err     <= w_sync_err_next;
      if (w_fall_tick) begin
        r_bit_cnt <= w_bit_next;
        r_lrck    <= w_bit_next[5];
        if (w_load) begin
          r_sdata <= 1'b0;
          r_shift <= r_pair_full ? {r_hold_l, r_hold_r} : '0;
        end else if (w_data_bit) begin
          r_sdata <= r_shift[2*AUDIO_WIDTH-1];
          r_shift <= {r_shift[2*AUDIO_WIDTH-2:0], 1'b0};
        end else begin
          r_sdata <= 1'b0;
        end
      end
    end
  end

  assign s_axis_ready = r_ready;
  assign i2s_bclk     = r_bclk;
  assign i2s_lrck     = r_lrck;
  assign i2s_sdata    = r_sdata;
  assign underrun     = r_underrun;
  assign sync_err     = r_sync_err;

endmodule

// File: tb/tb_axis_i2s_transmitter.sv
// tb_axis_i2s_transmitter
//   Drives AXIS words into axis_i2s_transmitter, decodes the I2S stream as a
//   receiver would (sampling on BCLK rise), and compares decoded frames,
//   underrun timing and sync errors against a pair/frame schedule model.
module tb_axis_i2s_transmitter;
  localparam int unsigned DIV   = 4;
  localparam int          FRAME = 64 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_axis_data = '0;
  logic        s_axis_valid = 1'b0;
  logic        s_axis_last = 1'b0;
  logic        s_axis_ready, i2s_bclk, i2s_lrck, i2s_sdata, underrun, sync_err;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Receiver-side capture
  logic [5:0]  mon_idx;
  logic        mon_prev;
  logic [63:0] mon_bits;
  int          mon_lrck_bad, mon_ones, mon_se;
  logic [63:0] fr_bits[$];
  int          ur_edges[$];

  // Stimulus record and model output
  logic [31:0] sent_data[$];
  logic        sent_last[$];
  int          sent_edge[$];
  logic [23:0] exp_left[$], exp_right[$];
  logic        exp_ur[$];
  int          exp_se;

  axis_i2s_transmitter #(
    .DATA_WIDTH (32),
    .AUDIO_WIDTH(24),
    .BCLK_DIV   (DIV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_axis_data (s_axis_data),
    .s_axis_valid(s_axis_valid),
    .s_axis_ready(s_axis_ready),
    .s_axis_last (s_axis_last),
    .i2s_bclk    (i2s_bclk),
    .i2s_lrck    (i2s_lrck),
    .i2s_sdata   (i2s_sdata),
    .underrun    (underrun),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  // Edge number since reset release: first edge with rst low is 1.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst) begin
      mon_idx      <= '0;
      mon_prev     <= 1'b0;
      mon_bits     <= '0;
      mon_lrck_bad <= 0;
      mon_ones     <= 0;
      mon_se       <= 0;
      fr_bits.delete();
      ur_edges.delete();
    end else begin
      mon_prev <= i2s_bclk;
      if (i2s_sdata === 1'b1) mon_ones <= mon_ones + 1;
      if (sync_err === 1'b1) mon_se <= mon_se + 1;
      if (underrun === 1'b1) ur_edges.push_back(cyc);
      if (i2s_bclk === 1'b1 && mon_prev === 1'b0) begin
        mon_bits[mon_idx] <= i2s_sdata;
        if (i2s_lrck !== mon_idx[5]) mon_lrck_bad <= mon_lrck_bad + 1;
        if (mon_idx == 6'd63) fr_bits.push_back({i2s_sdata, mon_bits[62:0]});
        mon_idx <= mon_idx + 6'd1;
      end
    end
  end

  function automatic logic [23:0] slot(input logic [63:0] b, input int base);
    logic [23:0] s;
    for (int j = 0; j < 24; j++) s[23-j] = b[base+1+j];
    return s;
  endfunction

  function automatic logic pad_bad(input logic [63:0] b);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 64; i++) if (((i % 32) == 0 || (i % 32) > 24) && b[i]) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic saw_ur(input int e);
    foreach (ur_edges[i]) if (ur_edges[i] == e) return 1'b1;
    return 1'b0;
  endfunction

  // Pairing rules give completed pairs; a pair goes out in frame k when it
  // completed strictly before load edge k*FRAME and earlier pairs are gone.
  function automatic void build_model(input int n);
    logic [23:0] pl[$], pr[$];
    int          pc[$];
    logic        want_r;
    logic [23:0] hl;
    want_r = 1'b0;
    hl     = '0;
    exp_se = 0;
    exp_left.delete(); exp_right.delete(); exp_ur.delete();
    foreach (sent_data[i]) begin
      if (!sent_last[i]) begin
        if (want_r) exp_se++;
        hl     = sent_data[i][23:0];
        want_r = 1'b1;
      end else if (want_r) begin
        pl.push_back(hl);
        pr.push_back(sent_data[i][23:0]);
        pc.push_back(sent_edge[i]);
        want_r = 1'b0;
      end else begin
        exp_se++;
      end
    end
    exp_left.push_back('0); exp_right.push_back('0); exp_ur.push_back(1'b0);
    for (int k = 1; k < n; k++) begin
      if (pc.size() > 0 && pc[0] < k * FRAME) begin
        exp_left.push_back(pl.pop_front());
        exp_right.push_back(pr.pop_front());
        void'(pc.pop_front());
        exp_ur.push_back(1'b0);
      end else begin
        exp_left.push_back('0); exp_right.push_back('0); exp_ur.push_back(1'b1);
      end
    end
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    s_axis_valid = 1'b0;
    sent_data.delete(); sent_last.delete(); sent_edge.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_edge(input int target);
    for (int t = 0; t < 200000 && cyc < target; t++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic l);
    bit done;
    done = 1'b0;
    s_axis_data  = d;
    s_axis_last  = l;
    s_axis_valid = 1'b1;
    for (int t = 0; t < 2000 && !done; t++) begin
      @(negedge clk);
      if (s_axis_ready === 1'b1) begin
        @(posedge clk); #1;
        sent_data.push_back(d); sent_last.push_back(l); sent_edge.push_back(cyc);
        done = 1'b1;
      end
    end
    s_axis_valid = 1'b0;
    if (!done) begin
      checks++; fails++;
      $display("FAIL send_word: ready never seen for data %h, required ready=1", d);
    end
  endtask

  task automatic test_reset();
    do_reset();
    send_word(32'h00123456, 1'b0); send_word(32'h00654321, 1'b1);
    send_word(32'h00777777, 1'b0); send_word(32'h00888888, 1'b1);
    wait_edge(300);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (i2s_bclk !== 1'b0) begin fails++; $display("FAIL reset bclk: got %b required 0", i2s_bclk); end
    checks++; if (i2s_lrck !== 1'b0) begin fails++; $display("FAIL reset lrck: got %b required 0", i2s_lrck); end
    checks++; if (i2s_sdata !== 1'b0) begin fails++; $display("FAIL reset sdata: got %b required 0", i2s_sdata); end
    checks++; if (s_axis_ready !== 1'b0) begin fails++; $display("FAIL reset ready: got %b required 0", s_axis_ready); end
    checks++; if (underrun !== 1'b0) begin fails++; $display("FAIL reset underrun: got %b required 0", underrun); end
    checks++; if (sync_err !== 1'b0) begin fails++; $display("FAIL reset sync_err: got %b required 0", sync_err); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (s_axis_ready !== 1'b1) begin fails++; $display("FAIL reset ready_after: got %b required 1", s_axis_ready); end
    wait_edge(32 * DIV - 1);
    checks++; if (i2s_lrck !== 1'b0) begin fails++; $display("FAIL reset lrck_before_rise: got %b required 0", i2s_lrck); end
    wait_edge(32 * DIV);
    checks++; if (i2s_lrck !== 1'b1) begin fails++; $display("FAIL reset lrck_rise: got %b required 1", i2s_lrck); end
    wait_edge(2 * FRAME - 1);
    // The pair held before reset must have been discarded.
    checks++; if (saw_ur(FRAME) !== 1'b1) begin fails++; $display("FAIL reset discard_underrun: got 0 required 1"); end
    checks++;
    if (fr_bits.size() < 2 || fr_bits[1] !== 64'd0) begin
      fails++; $display("FAIL reset discard_frame: got %0d frames/%h required zero frame 1", fr_bits.size(),
                        fr_bits.size() < 2 ? 64'hx : fr_bits[1]);
    end
  endtask

  task automatic test_nominal();
    int n;
    n = 2;
    do_reset();
    send_word(32'h5AABCDEF, 1'b0);
    send_word(32'h00800001, 1'b1);
    wait_edge(n * FRAME - 1);
    build_model(n);
    checks++; if (fr_bits.size() < n) begin fails++; $display("FAIL nominal frames: got %0d required %0d", fr_bits.size(), n); end
    else for (int k = 0; k < n; k++) begin
      checks++; if (slot(fr_bits[k], 0) !== exp_left[k]) begin fails++; $display("FAIL nominal left[%0d]: got %h required %h", k, slot(fr_bits[k], 0), exp_left[k]); end
      checks++; if (slot(fr_bits[k], 32) !== exp_right[k]) begin fails++; $display("FAIL nominal right[%0d]: got %h required %h", k, slot(fr_bits[k], 32), exp_right[k]); end
      checks++; if (pad_bad(fr_bits[k]) !== 1'b0) begin fails++; $display("FAIL nominal pad[%0d]: got nonzero padding required 0", k); end
    end
    checks++; if (ur_edges.size() != 0) begin fails++; $display("FAIL nominal underrun: got %0d pulses required 0", ur_edges.size()); end
    checks++; if (mon_lrck_bad != 0) begin fails++; $display("FAIL nominal lrck: got %0d misaligned bits required 0", mon_lrck_bad); end
  endtask

  task automatic test_starvation();
    do_reset();
    wait_edge(4 * FRAME - 24);
    checks++; if (ur_edges.size() != 3) begin fails++; $display("FAIL starve count: got %0d required 3", ur_edges.size()); end
    else begin
      checks++; if (ur_edges[0] != FRAME) begin fails++; $display("FAIL starve first: got %0d required %0d", ur_edges[0], FRAME); end
      checks++; if (ur_edges[1] - ur_edges[0] != FRAME) begin fails++; $display("FAIL starve spacing1: got %0d required %0d", ur_edges[1] - ur_edges[0], FRAME); end
      checks++; if (ur_edges[2] - ur_edges[1] != FRAME) begin fails++; $display("FAIL starve spacing2: got %0d required %0d", ur_edges[2] - ur_edges[1], FRAME); end
    end
    checks++; if (mon_ones != 0) begin fails++; $display("FAIL starve sdata: got %0d high cycles required 0", mon_ones); end
  endtask

  task automatic test_backpressure();
    int n;
    n = 4;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      send_word($urandom(), 1'b0);
      send_word($urandom(), 1'b1);
      @(negedge clk);
      checks++; if (s_axis_ready !== 1'b0) begin fails++; $display("FAIL bp ready_low[%0d]: got %b required 0", p, s_axis_ready); end
    end
    for (int p = 1; p < 3; p++) begin
      checks++;
      if (sent_edge[2*p] != p * FRAME + 1) begin
        fails++; $display("FAIL bp left_accept[%0d]: got edge %0d required %0d", p, sent_edge[2*p], p * FRAME + 1);
      end
    end
    wait_edge(n * FRAME - 1);
    build_model(n);
    checks++; if (fr_bits.size() < n) begin fails++; $display("FAIL bp frames: got %0d required %0d", fr_bits.size(), n); end
    else for (int k = 0; k < n; k++) begin
      checks++; if (slot(fr_bits[k], 0) !== exp_left[k]) begin fails++; $display("FAIL bp left[%0d]: got %h required %h", k, slot(fr_bits[k], 0), exp_left[k]); end
      checks++; if (slot(fr_bits[k], 32) !== exp_right[k]) begin fails++; $display("FAIL bp right[%0d]: got %h required %h", k, slot(fr_bits[k], 32), exp_right[k]); end
      if (k > 0) begin
        checks++; if (saw_ur(k * FRAME) !== exp_ur[k]) begin fails++; $display("FAIL bp underrun[%0d]: got %b required %b", k, saw_ur(k * FRAME), exp_ur[k]); end
      end
    end
  endtask

  task automatic test_misorder();
    int n;
    n = 2;
    do_reset();
    send_word(32'h00111111, 1'b1);
    send_word(32'h00222222, 1'b0);
    send_word(32'h00333333, 1'b0);
    send_word(32'h00444444, 1'b1);
    wait_edge(n * FRAME - 1);
    build_model(n);
    checks++; if (mon_se != exp_se) begin fails++; $display("FAIL misorder sync_err: got %0d required %0d", mon_se, exp_se); end
    checks++; if (fr_bits.size() < n) begin fails++; $display("FAIL misorder frames: got %0d required %0d", fr_bits.size(), n); end
    else begin
      checks++; if (slot(fr_bits[1], 0) !== exp_left[1]) begin fails++; $display("FAIL misorder left: got %h required %h", slot(fr_bits[1], 0), exp_left[1]); end
      checks++; if (slot(fr_bits[1], 32) !== exp_right[1]) begin fails++; $display("FAIL misorder right: got %h required %h", slot(fr_bits[1], 32), exp_right[1]); end
    end
  endtask

  task automatic test_boundary();
    int n;
    n = 3;
    do_reset();
    send_word(32'h00A5A5A5, 1'b0);
    wait_edge(FRAME - 1);
    send_word(32'h005A5A5A, 1'b1);
    checks++; if (sent_edge[1] != FRAME) begin fails++; $display("FAIL boundary accept_edge: got %0d required %0d", sent_edge[1], FRAME); end
    wait_edge(n * FRAME - 1);
    build_model(n);
    checks++; if (fr_bits.size() < n) begin fails++; $display("FAIL boundary frames: got %0d required %0d", fr_bits.size(), n); end
    else for (int k = 1; k < n; k++) begin
      checks++; if (slot(fr_bits[k], 0) !== exp_left[k]) begin fails++; $display("FAIL boundary left[%0d]: got %h required %h", k, slot(fr_bits[k], 0), exp_left[k]); end
      checks++; if (slot(fr_bits[k], 32) !== exp_right[k]) begin fails++; $display("FAIL boundary right[%0d]: got %h required %h", k, slot(fr_bits[k], 32), exp_right[k]); end
      checks++; if (saw_ur(k * FRAME) !== exp_ur[k]) begin fails++; $display("FAIL boundary underrun[%0d]: got %b required %b", k, saw_ur(k * FRAME), exp_ur[k]); end
    end
  endtask

  task automatic test_random();
    int   n, gap, nur;
    logic l;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      gap = $urandom_range(0, 200);
      l   = logic'(i % 2);
      if ($urandom_range(0, 4) == 0) l = ~l;
      send_word($urandom(), l);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    n = sent_edge[sent_edge.size()-1] / FRAME + 3;
    wait_edge(n * FRAME - 1);
    build_model(n);
    nur = 0;
    foreach (exp_ur[k]) if (exp_ur[k]) nur++;
    checks++; if (mon_se != exp_se) begin fails++; $display("FAIL random sync_err: got %0d required %0d", mon_se, exp_se); end
    checks++; if (ur_edges.size() != nur) begin fails++; $display("FAIL random underrun_count: got %0d required %0d", ur_edges.size(), nur); end
    checks++; if (mon_lrck_bad != 0) begin fails++; $display("FAIL random lrck: got %0d misaligned bits required 0", mon_lrck_bad); end
    checks++; if (fr_bits.size() < n) begin fails++; $display("FAIL random frames: got %0d required %0d", fr_bits.size(), n); end
    else for (int k = 0; k < n; k++) begin
      checks++; if (slot(fr_bits[k], 0) !== exp_left[k]) begin fails++; $display("FAIL random left[%0d]: got %h required %h", k, slot(fr_bits[k], 0), exp_left[k]); end
      checks++; if (slot(fr_bits[k], 32) !== exp_right[k]) begin fails++; $display("FAIL random right[%0d]: got %h required %h", k, slot(fr_bits[k], 32), exp_right[k]); end
      checks++; if (pad_bad(fr_bits[k]) !== 1'b0) begin fails++; $display("FAIL random pad[%0d]: got nonzero padding required 0", k); end
      if (k > 0) begin
        checks++; if (saw_ur(k * FRAME) !== exp_ur[k]) begin fails++; $display("FAIL random underrun[%0d]: got %b required %b", k, saw_ur(k * FRAME), exp_ur[k]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_starvation();
    test_backpressure();
    test_misorder();
    test_boundary();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
